e203_exu_wbck_arbt: RTL and testbench

// - Write-back arbiter directly upstream of the general-purpose register file; drives its single write port.
// - Merges ALU results (single-cycle, in-order) with long-pipe results (LSU/MulDiv, out-of-band).
// - Long-pipe results land in a DP-entry FIFO; ALU has priority, except the FIFO head wins when full.
// - Exports pending state to the dispatch dependency check.

---
 rtl/e203_exu_wbck_arbt.sv | 122 ++++++++++++
 tb/tb_e203_exu_wbck_arbt.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_wbck_arbt.sv
// Write-back arbiter in front of the GPR write port: ALU results vs. buffered long-pipe results.
// Optional same-cycle long-pipe bypass when the FIFO is empty: define E203_WBCK_LONGP_BYPASS_EN.
module e203_exu_wbck_arbt #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5,
   parameter int unsigned DP = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_wbck_i_valid,
   output logic                     alu_wbck_i_ready,
   input  logic [DW-1:0]            alu_wbck_i_wdat,
   input  logic [AW-1:0]            alu_wbck_i_rdidx,
   input  logic                     longp_wbck_i_valid,
   output logic                     longp_wbck_i_ready,
   input  logic [DW-1:0]            longp_wbck_i_wdat,
   input  logic [AW-1:0]            longp_wbck_i_rdidx,
   input  logic                     longp_wbck_i_err,
   output logic                     rf_wbck_o_ena,
   output logic [DW-1:0]            rf_wbck_o_wdat,
   output logic [AW-1:0]            rf_wbck_o_rdidx,
   output logic                     longp_pend,
   output logic [$clog2(DP+1)-1:0]  longp_cnt
);
   localparam int unsigned CW = $clog2(DP + 1);
   localparam int unsigned PW = (DP > 1) ? $clog2(DP) : 1;
   localparam int unsigned EW = 1 + AW + DW;

   logic [EW-1:0] fifo_mem [DP];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt;

   logic          full;
   logic          head_vld;
   logic          head_err;
   logic [AW-1:0] head_rdidx;
   logic [DW-1:0] head_wdat;
   logic          bypass;
   logic          push;
   logic          pop;
   logic          grant_head;

   logic          win_vld;
   logic          win_err;
   logic [AW-1:0] win_rdidx;
   logic [DW-1:0] win_wdat;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full     = (cnt == CW'(DP));
   assign head_vld = (cnt != '0);
   assign {head_err, head_rdidx, head_wdat} = fifo_mem[rd_ptr];

`ifdef E203_WBCK_LONGP_BYPASS_EN
   // Empty FIFO and idle ALU: long-pipe result goes straight to the write port.
   assign bypass = ~head_vld & ~alu_wbck_i_valid & longp_wbck_i_valid;
`else
   assign bypass = 1'b0;
`endif

   // The FIFO head yields to the ALU unless it is blocking further long-pipe pushes.
   assign grant_head         = head_vld & (~alu_wbck_i_valid | full);
   assign alu_wbck_i_ready   = ~(head_vld & full);
   assign longp_wbck_i_ready = ~full;
   assign push               = longp_wbck_i_valid & longp_wbck_i_ready & ~bypass;
   assign pop                = grant_head;

   always_comb begin
      win_vld   = 1'b0;
      win_err   = 1'b0;
      win_rdidx = '0;
      win_wdat  = '0;
      if (grant_head) begin
         win_vld   = 1'b1;
         win_err   = head_err;
         win_rdidx = head_rdidx;
         win_wdat  = head_wdat;
      end else if (bypass) begin
         win_vld   = 1'b1;
         win_err   = longp_wbck_i_err;
         win_rdidx = longp_wbck_i_rdidx;
         win_wdat  = longp_wbck_i_wdat;
      end else if (alu_wbck_i_valid & alu_wbck_i_ready) begin
         win_vld   = 1'b1;
         win_rdidx = alu_wbck_i_rdidx;
         win_wdat  = alu_wbck_i_wdat;
      end
   end

   // Errored results and x0 writes are consumed without touching the regfile.
   assign rf_wbck_o_ena   = win_vld & ~win_err & (win_rdidx != '0);
   assign rf_wbck_o_wdat  = win_wdat;
   assign rf_wbck_o_rdidx = win_rdidx;

   assign longp_pend = head_vld;
   assign longp_cnt  = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload storage needs no reset; occupancy is tracked by cnt.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {longp_wbck_i_err, longp_wbck_i_rdidx, longp_wbck_i_wdat};
   end

endmodule

// File: tb/tb_e203_exu_wbck_arbt.sv
// Bench for e203_exu_wbck_arbt: queue-based reference model plus directed literal checks.
module tb_e203_exu_wbck_arbt;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned DP = 2;
   localparam int unsigned CW = $clog2(DP + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_wbck_i_valid;
   logic          alu_wbck_i_ready;
   logic [DW-1:0] alu_wbck_i_wdat;
   logic [AW-1:0] alu_wbck_i_rdidx;
   logic          longp_wbck_i_valid;
   logic          longp_wbck_i_ready;
   logic [DW-1:0] longp_wbck_i_wdat;
   logic [AW-1:0] longp_wbck_i_rdidx;
   logic          longp_wbck_i_err;
   logic          rf_wbck_o_ena;
   logic [DW-1:0] rf_wbck_o_wdat;
   logic [AW-1:0] rf_wbck_o_rdidx;
   logic          longp_pend;
   logic [CW-1:0] longp_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic          err;
      logic [AW-1:0] idx;
      logic [DW-1:0] dat;
   } ent_t;

   ent_t q[$];
   int   sel;  // 0 idle, 1 fifo head, 2 bypass, 3 alu

   e203_exu_wbck_arbt #(.DW(DW), .AW(AW), .DP(DP)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .alu_wbck_i_valid   (alu_wbck_i_valid),
      .alu_wbck_i_ready   (alu_wbck_i_ready),
      .alu_wbck_i_wdat    (alu_wbck_i_wdat),
      .alu_wbck_i_rdidx   (alu_wbck_i_rdidx),
      .longp_wbck_i_valid (longp_wbck_i_valid),
      .longp_wbck_i_ready (longp_wbck_i_ready),
      .longp_wbck_i_wdat  (longp_wbck_i_wdat),
      .longp_wbck_i_rdidx (longp_wbck_i_rdidx),
      .longp_wbck_i_err   (longp_wbck_i_err),
      .rf_wbck_o_ena      (rf_wbck_o_ena),
      .rf_wbck_o_wdat     (rf_wbck_o_wdat),
      .rf_wbck_o_rdidx    (rf_wbck_o_rdidx),
      .longp_pend         (longp_pend),
      .longp_cnt          (longp_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against what the queue model says this cycle must produce.
   task automatic model_compare();
      int   sz;
      bit   full;
      bit   byp;
      ent_t w;
      bit   exp_ena;
      logic [DW-1:0] exp_dat;
      logic [AW-1:0] exp_idx;
      sz   = q.size();
      full = (sz == DP);
      byp  = 1'b0;
`ifdef E203_WBCK_LONGP_BYPASS_EN
      byp = (sz == 0) && !alu_wbck_i_valid && longp_wbck_i_valid;
`endif
      w = '{err: 1'b0, idx: '0, dat: '0};
      if (sz > 0 && (!alu_wbck_i_valid || full)) begin
         sel = 1; w = q[0];
      end else if (byp) begin
         sel = 2; w = '{err: longp_wbck_i_err, idx: longp_wbck_i_rdidx, dat: longp_wbck_i_wdat};
      end else if (alu_wbck_i_valid && !full) begin
         sel = 3; w = '{err: 1'b0, idx: alu_wbck_i_rdidx, dat: alu_wbck_i_wdat};
      end else begin
         sel = 0;
      end
      exp_ena = (sel != 0) && !w.err && (w.idx != 0);
      exp_dat = (sel != 0) ? w.dat : '0;
      exp_idx = (sel != 0) ? w.idx : '0;
      chk("m_ena",    64'(rf_wbck_o_ena),      64'(exp_ena));
      chk("m_wdat",   64'(rf_wbck_o_wdat),     64'(exp_dat));
      chk("m_rdidx",  64'(rf_wbck_o_rdidx),    64'(exp_idx));
      chk("m_aready", 64'(alu_wbck_i_ready),   64'(!full));
      chk("m_lready", 64'(longp_wbck_i_ready), 64'(!full));
      chk("m_pend",   64'(longp_pend),         64'(sz > 0));
      chk("m_cnt",    64'(longp_cnt),          64'(sz));
   endtask

   task automatic apply(input bit av, input logic [AW-1:0] aidx, input logic [DW-1:0] adat,
                        input bit lv, input logic [AW-1:0] lidx, input logic [DW-1:0] ldat,
                        input bit lerr);
      @(negedge clk);
      alu_wbck_i_valid   = av;
      alu_wbck_i_rdidx   = aidx;
      alu_wbck_i_wdat    = adat;
      longp_wbck_i_valid = lv;
      longp_wbck_i_rdidx = lidx;
      longp_wbck_i_wdat  = ldat;
      longp_wbck_i_err   = lerr;
      #1;
      model_compare();
   endtask

   task automatic commit();
      bit full;
      @(posedge clk);
      full = (q.size() == DP);
      if (sel == 1) void'(q.pop_front());
      if (longp_wbck_i_valid && !full && sel != 2)
         q.push_back('{err: longp_wbck_i_err, idx: longp_wbck_i_rdidx, dat: longp_wbck_i_wdat});
   endtask

   task automatic idle_cycle();
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      commit();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ena"},    64'(rf_wbck_o_ena),      64'd0);
      chk({tag, "_pend"},   64'(longp_pend),         64'd0);
      chk({tag, "_cnt"},    64'(longp_cnt),          64'd0);
      chk({tag, "_aready"}, 64'(alu_wbck_i_ready),   64'd1);
      chk({tag, "_lready"}, 64'(longp_wbck_i_ready), 64'd1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      alu_wbck_i_valid = 1'b0; alu_wbck_i_rdidx = '0; alu_wbck_i_wdat = '0;
      longp_wbck_i_valid = 1'b0; longp_wbck_i_rdidx = '0; longp_wbck_i_wdat = '0;
      longp_wbck_i_err = 1'b0;
      sel = 0;
      #3;
      chk_reset_vals("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ALU alone: written in the same cycle
      apply(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
      chk("alu_ena",    64'(rf_wbck_o_ena),    64'd1);
      chk("alu_rdidx",  64'(rf_wbck_o_rdidx),  64'd5);
      chk("alu_wdat",   64'(rf_wbck_o_wdat),   64'hDEADBEEF);
      chk("alu_ready",  64'(alu_wbck_i_ready), 64'd1);
      commit();

      // Contention: ALU wins, long-pipe lands next cycle
      apply(1'b1, 5'd3, 32'h1, 1'b1, 5'd7, 32'h12345678, 1'b0);
      chk("cont0_rdidx", 64'(rf_wbck_o_rdidx), 64'd3);
      chk("cont0_wdat",  64'(rf_wbck_o_wdat),  64'h1);
      chk("cont0_cnt",   64'(longp_cnt),       64'd0);
      commit();
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      chk("cont1_ena",   64'(rf_wbck_o_ena),   64'd1);
      chk("cont1_rdidx", 64'(rf_wbck_o_rdidx), 64'd7);
      chk("cont1_wdat",  64'(rf_wbck_o_wdat),  64'h12345678);
      chk("cont1_cnt",   64'(longp_cnt),       64'd1);
      commit();
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      chk("cont2_cnt",   64'(longp_cnt),       64'd0);
      commit();

      // Full FIFO: head preempts a continuously valid ALU
      apply(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA0A0, 1'b0); commit();
      apply(1'b1, 5'd2, 32'h22, 1'b1, 5'd11, 32'hB0B0, 1'b0); commit();
      apply(1'b1, 5'd3, 32'h33, 1'b0, '0, '0, 1'b0);
      chk("full_cnt",    64'(longp_cnt),          64'd2);
      chk("full_lready", 64'(longp_wbck_i_ready), 64'd0);
      chk("full_aready", 64'(alu_wbck_i_ready),   64'd0);
      chk("full_rdidx",  64'(rf_wbck_o_rdidx),    64'd10);
      chk("full_wdat",   64'(rf_wbck_o_wdat),     64'hA0A0);
      commit();
      apply(1'b1, 5'd3, 32'h33, 1'b0, '0, '0, 1'b0);
      chk("resume_cnt",    64'(longp_cnt),        64'd1);
      chk("resume_aready", 64'(alu_wbck_i_ready), 64'd1);
      chk("resume_rdidx",  64'(rf_wbck_o_rdidx),  64'd3);
      commit();
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      chk("drainb_rdidx", 64'(rf_wbck_o_rdidx), 64'd11);
      commit();

      // Errored long-pipe result is consumed without a write
      apply(1'b0, '0, '0, 1'b1, 5'd9, 32'hCAFE, 1'b1);
      chk("err0_ena", 64'(rf_wbck_o_ena), 64'd0);
      commit();
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      chk("err1_ena", 64'(rf_wbck_o_ena), 64'd0);
`ifndef E203_WBCK_LONGP_BYPASS_EN
      chk("err1_cnt", 64'(longp_cnt), 64'd1);
`endif
      commit();
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      chk("err2_cnt", 64'(longp_cnt), 64'd0);
      commit();

      // x0 destination is never written
      apply(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b0);
      chk("x0_ready", 64'(alu_wbck_i_ready), 64'd1);
      chk("x0_ena",   64'(rf_wbck_o_ena),    64'd0);
      commit();

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         apply(($urandom_range(99) < 55),
               AW'($urandom_range(31)), $urandom(),
               ($urandom_range(99) < 45),
               AW'($urandom_range(31)), $urandom(),
               ($urandom_range(99) < 15));
         commit();
      end

      // Leave an entry pending, then reset mid-operation
      apply(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hC0C0, 1'b0);
      commit();
      @(negedge clk);
      alu_wbck_i_valid = 1'b0; longp_wbck_i_valid = 1'b0; longp_wbck_i_err = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         apply(($urandom_range(99) < 40),
               AW'($urandom_range(31)), $urandom(),
               ($urandom_range(99) < 60),
               AW'($urandom_range(31)), $urandom(),
               ($urandom_range(99) < 20));
         commit();
      end

      n = 0;
      while (q.size() != 0 && n < 20) begin
         idle_cycle();
         n++;
      end
      @(negedge clk);
      #1 chk("drain_cnt", 64'(longp_cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
